// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, WB control bit indices and stage state encoding
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 2;
  localparam int PIPE_RD_W   = 5;
  localparam int CTRL_REGWR  = 0;
  localparam int CTRL_MEMSEL = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry (valid, ctrl, data, rd) with load and clear
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int RD_W   = PIPE_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic [RD_W-1:0]   i_rd,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [RD_W-1:0]   o_rd
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;

  // Clear only drops the valid bit; payload moves only when a load is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_rd    <= '0;
    end else begin
      if (i_clear)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      if (i_load) begin
        r_ctrl <= i_ctrl;
        r_data <= i_data;
        r_rd   <= i_rd;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;
  assign o_rd    = r_rd;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register; PIPE_SKID_BUFFER_EN adds a second (skid) entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int RD_W   = PIPE_RD_W
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  pipe_state_t       r_state;
  logic              w_accept;
  logic              w_release;
  logic              w_head_load;
  logic              w_head_clear;
  logic              w_head_valid;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [DATA_W-1:0] w_head_data;
  logic [RD_W-1:0]   w_head_rd;
  logic [CTRL_W-1:0] w_src_ctrl;
  logic [DATA_W-1:0] w_src_data;
  logic [RD_W-1:0]   w_src_rd;

  assign w_accept  = in_valid & in_ready;
  assign w_release = w_head_valid & out_ready;

`ifdef PIPE_SKID_BUFFER_EN
  logic              r_not_full;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [RD_W-1:0]   w_skid_rd;

  assign in_ready     = r_not_full & ~flush;
  // Head refills from the skid entry when draining TWO, otherwise straight from the input.
  assign w_head_load  = ~flush & ((w_accept & ((r_state == ST_EMPTY) | w_release)) |
                                  ((r_state == ST_TWO) & w_release));
  assign w_src_ctrl   = (r_state == ST_TWO) ? w_skid_ctrl : in_ctrl;
  assign w_src_data   = (r_state == ST_TWO) ? w_skid_data : in_data;
  assign w_src_rd     = (r_state == ST_TWO) ? w_skid_rd   : in_rd;
  assign w_skid_load  = ~flush & w_accept & (r_state == ST_ONE) & ~w_release;
  assign w_skid_clear = flush | ((r_state == ST_TWO) & w_release);

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
    .clk     (reloj),
    .rst     (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .i_rd    (in_rd),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data),
    .o_rd    (w_skid_rd)
  );
`else
  assign in_ready    = (~w_head_valid | out_ready) & ~flush;
  assign w_head_load = w_accept;
  assign w_src_ctrl  = in_ctrl;
  assign w_src_data  = in_data;
  assign w_src_rd    = in_rd;
`endif

  assign w_head_clear = flush | (w_release & ~w_head_load);

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_head (
    .clk     (reloj),
    .rst     (reset),
    .i_load  (w_head_load),
    .i_clear (w_head_clear),
    .i_ctrl  (w_src_ctrl),
    .i_data  (w_src_data),
    .i_rd    (w_src_rd),
    .o_valid (w_head_valid),
    .o_ctrl  (w_head_ctrl),
    .o_data  (w_head_data),
    .o_rd    (w_head_rd)
  );

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
`ifdef PIPE_SKID_BUFFER_EN
      r_not_full <= 1'b1;
`endif
    end else if (flush) begin
      r_state    <= ST_EMPTY;
`ifdef PIPE_SKID_BUFFER_EN
      r_not_full <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_release && !w_accept)
            r_state <= ST_EMPTY;
`ifdef PIPE_SKID_BUFFER_EN
          else if (w_accept && !w_release) begin
            r_state    <= ST_TWO;
            r_not_full <= 1'b0;
          end
`endif
        end
`ifdef PIPE_SKID_BUFFER_EN
        ST_TWO: if (w_release) begin
          r_state    <= ST_ONE;
          r_not_full <= 1'b1;
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = w_head_valid;
  assign out_ctrl  = w_head_ctrl & {CTRL_W{w_head_valid}};
  assign out_data  = w_head_data;
  assign out_rd    = w_head_rd;
  assign occupancy = state_occupancy(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (either PIPE_SKID_BUFFER_EN setting)
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        reloj = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_ctrl, out_ctrl, occupancy;
  logic [63:0] in_data, out_data;
  logic [4:0]  in_rd, out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  c;
    logic [63:0] d;
    logic [4:0]  r;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic        iv, ordy, fl;
    logic [1:0]  c;
    logic [63:0] d;
    logic [4:0]  r;
    logic        eov;
    logic [1:0]  ec;
    logic [63:0] ed;
    logic [4:0]  er;
    logic [1:0]  eocc;
  } vec_t;
  vec_t tbl[8];

  pipe_stage_reg dut (
    .reloj(reloj), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_rd(out_rd), .occupancy(occupancy)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
    in_valid = iv; out_ready = ordy; flush = fl; in_ctrl = c; in_data = d; in_rd = r;
  endtask

  // Reference: a FIFO of accepted entries with capacity 1 or 2, drained from the front.
  task automatic model_cycle(input string name, input logic iv, input logic ordy, input logic fl,
                             input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
    int   n;
    logic exp_ir, acc, rel;
    ent_t e;
    @(negedge reloj);
    drive(iv, ordy, fl, c, d, r);
    #1;
    n = q.size();
    exp_ir = !fl && (SKID ? (n < 2) : (n == 0 || ordy));
    if (n > 0)
      chk(name, {out_valid, out_ctrl, out_data, out_rd, occupancy, in_ready},
                {1'b1, q[0].c, q[0].d, q[0].r, 2'(n), exp_ir});
    else
      chk(name, {out_valid, out_ctrl, occupancy, in_ready}, {1'b0, 2'b00, 2'd0, exp_ir});
    acc = iv && exp_ir;
    rel = (n > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (rel) void'(q.pop_front());
      if (acc) begin e.c = c; e.d = d; e.r = r; q.push_back(e); end
    end
  endtask

  task automatic edge_step(input logic iv, input logic ordy, input logic fl,
                           input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
    @(negedge reloj);
    drive(iv, ordy, fl, c, d, r);
    @(posedge reloj);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 5'd0);
    reset = 1'b1;
    #1;
    chk("reset_state", {out_valid, out_ctrl, out_data, out_rd, occupancy},
                       {1'b0, 2'b00, 64'h0, 5'd0, 2'd0});
    repeat (2) @(posedge reloj);
    @(negedge reloj);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {127'h0, in_ready}, {127'h0, 1'b1});

    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'b11, 64'hDEAD_BEEF_0000_0004, 5'd7,
               1'b1, 2'b11, 64'hDEAD_BEEF_0000_0004, 5'd7, 2'd1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2'b01, 64'h0000_0000_0000_0005, 5'd8,
               1'b1, 2'b01, 64'h0000_0000_0000_0005, 5'd8, 2'd1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31,
               1'b0, 2'b00, 64'h0000_0000_0000_0005, 5'd8, 2'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 2'b11, 64'h1111_2222_3333_4444, 5'd9,
               1'b0, 2'b00, 64'h0000_0000_0000_0005, 5'd8, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2'b10, 64'h0000_0000_0000_0006, 5'd3,
               1'b1, 2'b10, 64'h0000_0000_0000_0006, 5'd3, 2'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2'b01, 64'h0000_0000_0000_0099, 5'd4,
               1'b1, 2'b10, 64'h0000_0000_0000_0006, 5'd3, 2'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 2'b01, 64'h0000_0000_0000_0099, 5'd4,
               1'b0, 2'b00, 64'h0000_0000_0000_0006, 5'd3, 2'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 2'b11, 64'h0000_0000_0000_0007, 5'd1,
               1'b0, 2'b00, 64'h0000_0000_0000_0006, 5'd3, 2'd0};
    for (int i = 0; i < 8; i++) begin
      edge_step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].c, tbl[i].d, tbl[i].r);
      chk($sformatf("table_row%0d", i), {out_valid, out_ctrl, out_data, out_rd, occupancy},
          {tbl[i].eov, tbl[i].ec, tbl[i].ed, tbl[i].er, tbl[i].eocc});
    end

    // Back-pressure: push A then B while downstream is stalled, then drain.
    edge_step(1'b1, 1'b0, 1'b0, 2'b01, 64'hA, 5'd1);
    chk("bp_first", {out_valid, out_data, occupancy}, {1'b1, 64'hA, 2'd1});
    edge_step(1'b1, 1'b0, 1'b0, 2'b10, 64'hB, 5'd2);
    chk("bp_second", {in_ready, out_valid, out_ctrl, out_data, out_rd, occupancy},
        {1'b0, 1'b1, 2'b01, 64'hA, 5'd1, SKID ? 2'd2 : 2'd1});
    @(negedge reloj);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 5'd0);
    #1;
    chk("drain_head", {out_valid, out_data}, {1'b1, 64'hA});
    @(posedge reloj); #1;
    if (SKID) chk("drain_skid", {out_valid, out_ctrl, out_data, out_rd, occupancy},
                  {1'b1, 2'b10, 64'hB, 5'd2, 2'd1});
    else      chk("drain_done", {out_valid, out_ctrl, occupancy}, {1'b0, 2'b00, 2'd0});
    edge_step(1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 5'd0);
    chk("drain_empty", {out_valid, occupancy}, {1'b0, 2'd0});

    // Flush while full with a simultaneous offer from upstream.
    edge_step(1'b1, 1'b0, 1'b0, 2'b11, 64'hC, 5'd5);
    edge_step(1'b1, 1'b0, 1'b0, 2'b11, 64'hD, 5'd6);
    @(negedge reloj);
    drive(1'b1, 1'b1, 1'b1, 2'b11, 64'hE, 5'd7);
    #1;
    chk("flush_ready_low", {127'h0, in_ready}, {127'h0, 1'b0});
    @(posedge reloj); #1;
    chk("flush_clears", {out_valid, out_ctrl, occupancy}, {1'b0, 2'b00, 2'd0});
    edge_step(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 5'd0);
    chk("flush_no_accept", {out_valid, occupancy}, {1'b0, 2'd0});

    // Asynchronous reset pulse between edges.
    edge_step(1'b1, 1'b0, 1'b0, 2'b11, 64'hF00D, 5'd9);
    chk("pre_async", {out_valid, out_data, occupancy}, {1'b1, 64'hF00D, 2'd1});
    @(negedge reloj);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 5'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {out_valid, out_ctrl, out_data, out_rd, occupancy},
                       {1'b0, 2'b00, 64'h0, 5'd0, 2'd0});
    #1 reset = 1'b0;
    q.delete();

    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic iv, ordy, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (cyc < 2000) ? 1'b1 : ($urandom_range(0, 99) < ((cyc / 1000) * 10));
      fl   = (cyc > 5000) && ($urandom_range(0, 63) == 0);
      model_cycle("random", iv, ordy, fl, 2'($urandom), {$urandom, $urandom}, 5'($urandom));
      if (n_fail > 20) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
